// File: rtl/trigger_cfg_seq.sv
// Trigger configuration sequencer: replays a preloaded (address, data) table onto the
// trigger write bus on start. Optional abort support is built when TRIGGER_CFG_ABORT_EN is defined.
module trigger_cfg_seq #(
    parameter int BDW = 32,
    parameter int BAW = 6,
    parameter int CDP = 16,
    parameter int CAW = $clog2(CDP)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_wvalid,
    output logic           ld_wready,
    input  logic [BAW-1:0] ld_waddr,
    input  logic [BDW-1:0] ld_wdata,
    input  logic           ld_clr,
    input  logic           ctl_start,
    output logic           ctl_busy,
    output logic           ctl_done,
`ifdef TRIGGER_CFG_ABORT_EN
    input  logic           ctl_abort,
    output logic           ctl_abrt,
`endif
    output logic [CAW:0]   ctl_cnt,
    input  logic           bus_wready,
    output logic           bus_wvalid,
    output logic [BAW-1:0] bus_waddr,
    output logic [BDW-1:0] bus_wdata
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    localparam logic [CAW:0] CNT_FULL = (CAW+1)'(CDP);
    localparam logic [CAW:0] CNT_ONE  = (CAW+1)'(1);

    state_t               state;
    logic [CAW:0]         cnt;
    logic [CAW-1:0]       ptr;
    logic [CAW-1:0]       ptr_nxt;
    logic                 last;
    logic                 abort_req;
    logic [BAW+BDW-1:0]   tbl [CDP];

`ifdef TRIGGER_CFG_ABORT_EN
    assign abort_req = ctl_abort;
`else
    assign abort_req = 1'b0;
`endif

    assign ctl_cnt   = cnt;
    assign ptr_nxt   = ptr + CAW'(1);
    assign last      = ({1'b0, ptr} == (cnt - CNT_ONE));
    // Gated by rst so the load port reads not-ready while reset is held.
    assign ld_wready = rst && (state == IDLE) && !ld_clr && !ctl_start && (cnt < CNT_FULL);

    // Table storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (ld_wvalid && ld_wready)
            tbl[cnt[CAW-1:0]] <= {ld_waddr, ld_wdata};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            ctl_busy   <= 1'b0;
            ctl_done   <= 1'b0;
            bus_wvalid <= 1'b0;
            bus_waddr  <= '0;
            bus_wdata  <= '0;
`ifdef TRIGGER_CFG_ABORT_EN
            ctl_abrt   <= 1'b0;
`endif
        end else begin
            ctl_done <= 1'b0;
`ifdef TRIGGER_CFG_ABORT_EN
            ctl_abrt <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ld_clr)
                        cnt <= '0;
                    else if (ld_wvalid && ld_wready)
                        cnt <= cnt + CNT_ONE;
                    // A clear coinciding with start empties the table first, so nothing replays.
                    if (ctl_start) begin
                        if (ld_clr || cnt == '0) begin
                            state    <= DONE;
                            ctl_done <= 1'b1;
                        end else begin
                            state                  <= PLAY;
                            ptr                    <= '0;
                            ctl_busy               <= 1'b1;
                            bus_wvalid             <= 1'b1;
                            {bus_waddr, bus_wdata} <= tbl[0];
                        end
                    end
                end
                PLAY: begin
                    if ((bus_wready && last) || abort_req) begin
                        state      <= DONE;
                        ctl_busy   <= 1'b0;
                        bus_wvalid <= 1'b0;
                        ctl_done   <= 1'b1;
`ifdef TRIGGER_CFG_ABORT_EN
                        ctl_abrt   <= abort_req;
`endif
                    end else if (bus_wready) begin
                        ptr                    <= ptr_nxt;
                        {bus_waddr, bus_wdata} <= tbl[ptr_nxt];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_cfg_seq.sv
// Directed bench for trigger_cfg_seq; abort steps are included when TRIGGER_CFG_ABORT_EN is defined.
module tb_trigger_cfg_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_wvalid;
    logic        ld_wready;
    logic [5:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic        ld_clr;
    logic        ctl_start;
    logic        ctl_busy;
    logic        ctl_done;
    logic [4:0]  ctl_cnt;
    logic        bus_wready;
    logic        bus_wvalid;
    logic [5:0]  bus_waddr;
    logic [31:0] bus_wdata;
`ifdef TRIGGER_CFG_ABORT_EN
    logic        ctl_abort;
    logic        ctl_abrt;
`endif

    int total = 0;
    int bad   = 0;
    int hs;

    logic [5:0]  exp_a [3];
    logic [31:0] exp_d [3];

    trigger_cfg_seq #(.BDW(32), .BAW(6), .CDP(16)) dut (
        .clk(clk), .rst(rst),
        .ld_wvalid(ld_wvalid), .ld_wready(ld_wready), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
        .ld_clr(ld_clr), .ctl_start(ctl_start), .ctl_busy(ctl_busy), .ctl_done(ctl_done),
`ifdef TRIGGER_CFG_ABORT_EN
        .ctl_abort(ctl_abort), .ctl_abrt(ctl_abrt),
`endif
        .ctl_cnt(ctl_cnt), .bus_wready(bus_wready), .bus_wvalid(bus_wvalid),
        .bus_waddr(bus_waddr), .bus_wdata(bus_wdata)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        ld_wvalid = 1'b1;
        ld_waddr  = a;
        ld_wdata  = d;
        #1;
        chk("load_ready", 64'(ld_wready), 64'd1);
        step;
        ld_wvalid = 1'b0;
    endtask

    // Pulse start with bus_wready held high and check the 3-entry table replays back to back.
    task automatic replay3(input string tag, input logic pulse_load);
        bus_wready = 1'b1;
        ctl_start  = 1'b1;
        step;
        ctl_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (pulse_load && i == 1) begin
                ld_wvalid = 1'b1;
                #1;
                chk({tag, "_ldrdy_play"}, 64'(ld_wready), 64'd0);
            end
            chk({tag, "_wvalid"}, 64'(bus_wvalid), 64'd1);
            chk({tag, "_waddr"}, 64'(bus_waddr), 64'(exp_a[i]));
            chk({tag, "_wdata"}, 64'(bus_wdata), 64'(exp_d[i]));
            chk({tag, "_busy"}, 64'(ctl_busy), 64'd1);
            step;
            ld_wvalid = 1'b0;
        end
        chk({tag, "_done"}, 64'(ctl_done), 64'd1);
        chk({tag, "_wvalid_off"}, 64'(bus_wvalid), 64'd0);
        chk({tag, "_busy_off"}, 64'(ctl_busy), 64'd0);
        chk({tag, "_cnt"}, 64'(ctl_cnt), 64'd3);
        step;
        chk({tag, "_done_pulse"}, 64'(ctl_done), 64'd0);
    endtask

    initial begin
        rst = 1'b0; ld_wvalid = 1'b0; ld_waddr = '0; ld_wdata = '0; ld_clr = 1'b0;
        ctl_start = 1'b0; bus_wready = 1'b0;
`ifdef TRIGGER_CFG_ABORT_EN
        ctl_abort = 1'b0;
`endif
        exp_a[0] = 6'h01; exp_a[1] = 6'h02; exp_a[2] = 6'h03;
        exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;

        step;
        step;
        chk("rst_ldrdy", 64'(ld_wready), 64'd0);
        chk("rst_busy", 64'(ctl_busy), 64'd0);
        chk("rst_done", 64'(ctl_done), 64'd0);
        chk("rst_wvalid", 64'(bus_wvalid), 64'd0);
        chk("rst_cnt", 64'(ctl_cnt), 64'd0);
        chk("rst_waddr", 64'(bus_waddr), 64'd0);
        chk("rst_wdata", 64'(bus_wdata), 64'd0);
`ifdef TRIGGER_CFG_ABORT_EN
        chk("rst_abrt", 64'(ctl_abrt), 64'd0);
`endif
        rst = 1'b1;
        #1;
        chk("idle_ldrdy", 64'(ld_wready), 64'd1);

        // Basic 3-entry load and back-to-back replay.
        for (int i = 0; i < 3; i++) load(exp_a[i], exp_d[i]);
        chk("cnt3", 64'(ctl_cnt), 64'd3);
        ctl_start = 1'b1;
        #1;
        chk("start_blocks_load", 64'(ld_wready), 64'd0);
        ctl_start = 1'b0;
        replay3("play1", 1'b0);
        #1;
        chk("idle_again_ldrdy", 64'(ld_wready), 64'd1);

        // Re-arm without reloading, with a stray load during PLAY.
        replay3("play2", 1'b1);

        // bus_wready pattern 0,0,1 per entry.
        bus_wready = 1'b0;
        ctl_start  = 1'b1;
        step;
        ctl_start = 1'b0;
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                bus_wready = (k == 2);
                #1;
                chk("bp_wvalid", 64'(bus_wvalid), 64'd1);
                chk("bp_waddr", 64'(bus_waddr), 64'(exp_a[i]));
                chk("bp_wdata", 64'(bus_wdata), 64'(exp_d[i]));
                chk("bp_busy", 64'(ctl_busy), 64'd1);
                if (bus_wvalid && bus_wready) hs++;
                step;
            end
        end
        bus_wready = 1'b1;
        chk("bp_done", 64'(ctl_done), 64'd1);
        chk("bp_wvalid_off", 64'(bus_wvalid), 64'd0);
        chk("bp_handshakes", 64'(hs), 64'd3);
        step;

        // Clear beats a same-cycle load; start on an empty table.
        ld_clr = 1'b1; ld_wvalid = 1'b1; ld_waddr = 6'h3F; ld_wdata = 32'hDEAD;
        #1;
        chk("clr_ldrdy", 64'(ld_wready), 64'd0);
        step;
        ld_clr = 1'b0; ld_wvalid = 1'b0;
        chk("clr_cnt", 64'(ctl_cnt), 64'd0);
        ctl_start = 1'b1;
        step;
        ctl_start = 1'b0;
        chk("empty_done", 64'(ctl_done), 64'd1);
        chk("empty_wvalid", 64'(bus_wvalid), 64'd0);
        step;
        chk("empty_done_pulse", 64'(ctl_done), 64'd0);
        chk("empty_wvalid2", 64'(bus_wvalid), 64'd0);

        // Full table: 16 entries, 17th refused, replay in load order.
        for (int i = 0; i < 16; i++) load(6'(32'h20 + i), 32'h1000 + i);
        chk("full_cnt", 64'(ctl_cnt), 64'd16);
        ld_wvalid = 1'b1; ld_waddr = 6'h11; ld_wdata = 32'h5555;
        #1;
        chk("full_ldrdy", 64'(ld_wready), 64'd0);
        step;
        ld_wvalid = 1'b0;
        chk("full_cnt_sat", 64'(ctl_cnt), 64'd16);
        bus_wready = 1'b1;
        ctl_start  = 1'b1;
        step;
        ctl_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("full_wvalid", 64'(bus_wvalid), 64'd1);
            chk("full_waddr", 64'(bus_waddr), 64'(32'h20 + i));
            chk("full_wdata", 64'(bus_wdata), 64'(32'h1000 + i));
            step;
        end
        chk("full_done", 64'(ctl_done), 64'd1);
        chk("full_wvalid_off", 64'(bus_wvalid), 64'd0);
        step;

        // Reset during PLAY.
        ctl_start = 1'b1;
        step;
        ctl_start = 1'b0;
        step;
        chk("mid_wvalid_pre", 64'(bus_wvalid), 64'd1);
        rst = 1'b0;
        step;
        chk("mid_rst_wvalid", 64'(bus_wvalid), 64'd0);
        chk("mid_rst_cnt", 64'(ctl_cnt), 64'd0);
        chk("mid_rst_busy", 64'(ctl_busy), 64'd0);
        rst = 1'b1;
        step;

`ifdef TRIGGER_CFG_ABORT_EN
        // Abort in the cycle of the 3rd handshake of an 8-entry replay.
        for (int i = 0; i < 8; i++) load(6'(i + 1), 32'h100 + i);
        bus_wready = 1'b1;
        ctl_start  = 1'b1;
        step;
        ctl_start = 1'b0;
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            ctl_abort = (i == 2);
            chk("abt_waddr", 64'(bus_waddr), 64'(i + 1));
            if (bus_wvalid && bus_wready) hs++;
            step;
        end
        ctl_abort = 1'b0;
        chk("abt_writes", 64'(hs), 64'd3);
        chk("abt_done", 64'(ctl_done), 64'd1);
        chk("abt_abrt", 64'(ctl_abrt), 64'd1);
        chk("abt_wvalid", 64'(bus_wvalid), 64'd0);
        step;
        chk("abt_done_pulse", 64'(ctl_done), 64'd0);
        chk("abt_abrt_pulse", 64'(ctl_abrt), 64'd0);
        chk("abt_wvalid2", 64'(bus_wvalid), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
